// File: rtl/hazard_pkg.sv
// Shared constants for the MIPS hazard controller: forwarding select encodings
// and the default register-address width.
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_W   = 2'b01;
    localparam fwd_sel_t FWD_M   = 2'b10;

endpackage

// File: rtl/hazard_sb_if.sv
// Datapath <-> hazard controller signal bundle. The datapath (master) drives the
// pipeline register fields; the hazard unit (slave) returns forwards and stalls.
interface hazard_sb_if #(
    parameter int REG_AW = hazard_pkg::REG_AW,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
    logic [REG_AW-1:0] writeRegE, writeRegM, writeRegW;
    logic              regWriteE, regWriteM, regWriteW;
    logic              memToRegE, memToRegM;
    logic              branchD, pcSrcD;
    logic              mdStartE, mdDivE, mdUseD;
    logic              clrStallCnt;

    logic [1:0]        forwardAE, forwardBE;
    logic              forwardAD, forwardBD;
    logic              stallF, stallD, flushE, flushD;
    logic              mdBusy;
    logic [CNT_W-1:0]  stallCnt;

    modport master (
        output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
               branchD, pcSrcD, mdStartE, mdDivE, mdUseD, clrStallCnt,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, flushE, flushD, mdBusy, stallCnt
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
               branchD, pcSrcD, mdStartE, mdDivE, mdUseD, clrStallCnt,
        output forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, flushE, flushD, mdBusy, stallCnt
    );

endinterface

// File: rtl/hazard_md_tracker.sv
// HI/LO occupancy timer for the iterative mult/div unit: a down-counter loaded
// with the op latency when the op leaves E.
module hazard_md_tracker #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    localparam int MD_W = $clog2(DIV_LAT + 1);

    logic [MD_W-1:0] md_cnt_q, md_cnt_d;

    // A start while still counting reloads; the D-stage stall normally prevents it.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = md_div ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = md_start || (md_cnt_q != '0);

endmodule

// File: rtl/hazard_sb.sv
// Five-stage MIPS hazard controller: E/D forwarding, load-use / branch / HI/LO
// stalls, E/D flushes and a saturating stall-cycle counter.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_sb_if.slave  hz
);

    logic     a_hit_m, a_hit_w, b_hit_m, b_hit_w;
    logic     rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
    logic     lw_stall, branch_stall, md_stall, md_busy, stall;
    fwd_sel_t fwd_a, fwd_b;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Register 0 is hardwired to zero, so it never produces a hazard.
    assign a_hit_m  = hz.regWriteM && (hz.rsE != '0) && (hz.rsE == hz.writeRegM);
    assign a_hit_w  = hz.regWriteW && (hz.rsE != '0) && (hz.rsE == hz.writeRegW);
    assign b_hit_m  = hz.regWriteM && (hz.rtE != '0) && (hz.rtE == hz.writeRegM);
    assign b_hit_w  = hz.regWriteW && (hz.rtE != '0) && (hz.rtE == hz.writeRegW);

    assign rs_hit_e = (hz.rsD != '0) && (hz.rsD == hz.writeRegE);
    assign rt_hit_e = (hz.rtD != '0) && (hz.rtD == hz.writeRegE);
    assign rs_hit_m = (hz.rsD != '0) && (hz.rsD == hz.writeRegM);
    assign rt_hit_m = (hz.rtD != '0) && (hz.rtD == hz.writeRegM);

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (a_hit_m)      fwd_a = FWD_M;
        else if (a_hit_w) fwd_a = FWD_W;
        if (b_hit_m)      fwd_b = FWD_M;
        else if (b_hit_w) fwd_b = FWD_W;
    end

    hazard_md_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (hz.mdStartE),
        .md_div   (hz.mdDivE),
        .md_busy  (md_busy)
    );

    assign lw_stall     = hz.memToRegE && (rs_hit_e || rt_hit_e);
    assign branch_stall = hz.branchD &&
                          ((hz.regWriteE && (rs_hit_e || rt_hit_e)) ||
                           (hz.memToRegM && (rs_hit_m || rt_hit_m)));
    assign md_stall     = hz.mdUseD && md_busy;
    assign stall        = lw_stall || branch_stall || md_stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.clrStallCnt) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.forwardAE = fwd_a;
    assign hz.forwardBE = fwd_b;
    assign hz.forwardAD = hz.regWriteM && rs_hit_m;
    assign hz.forwardBD = hz.regWriteM && rt_hit_m;
    assign hz.stallF    = stall;
    assign hz.stallD    = stall;
    assign hz.flushE    = stall;
    // A taken branch held in D resolves again once the stall clears.
    assign hz.flushD    = hz.pcSrcD && !stall;
    assign hz.mdBusy    = md_busy;
    assign hz.stallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Directed-vector bench for hazard_sb with hand-computed expectations.
module tb_hazard_sb;

    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_sb_if #(.REG_AW(5), .CNT_W(CW)) hz ();

    hazard_sb #(.MUL_LAT(3), .DIV_LAT(16), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
        hz.writeRegE = '0; hz.writeRegM = '0; hz.writeRegW = '0;
        hz.regWriteE = 0; hz.regWriteM = 0; hz.regWriteW = 0;
        hz.memToRegE = 0; hz.memToRegM = 0;
        hz.branchD = 0; hz.pcSrcD = 0;
        hz.mdStartE = 0; hz.mdDivE = 0; hz.mdUseD = 0;
        hz.clrStallCnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        hz.clrStallCnt = 1;
        tick();
        hz.clrStallCnt = 0;
    endtask

    initial begin
        idle();
        #2;
        check("rst_stallD", {31'b0, hz.stallD}, 0);
        check("rst_flushD", {31'b0, hz.flushD}, 0);
        check("rst_mdBusy", {31'b0, hz.mdBusy}, 0);
        check("rst_fwdAE", {30'b0, hz.forwardAE}, 0);
        check("rst_cnt", {27'b0, hz.stallCnt}, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // E-stage forwarding priority and r0 gating
        hz.rsE = 5; hz.rtE = 5;
        hz.writeRegM = 5; hz.regWriteM = 1; hz.writeRegW = 5; hz.regWriteW = 1;
        #1;
        check("fwdAE_M", {30'b0, hz.forwardAE}, 2);
        check("fwdBE_M", {30'b0, hz.forwardBE}, 2);
        check("fwd_nostall", {31'b0, hz.stallD}, 0);
        hz.regWriteM = 0;
        #1;
        check("fwdAE_W", {30'b0, hz.forwardAE}, 1);
        hz.rtE = 6;
        #1;
        check("fwdBE_none", {30'b0, hz.forwardBE}, 0);
        hz.rsE = 0; hz.writeRegW = 0; hz.writeRegM = 0; hz.regWriteM = 1;
        #1;
        check("fwdAE_r0", {30'b0, hz.forwardAE}, 0);
        idle();

        // load-use stall
        hz.memToRegE = 1; hz.writeRegE = 8; hz.rtD = 8;
        #1;
        check("lw_stallF", {31'b0, hz.stallF}, 1);
        check("lw_stallD", {31'b0, hz.stallD}, 1);
        check("lw_flushE", {31'b0, hz.flushE}, 1);
        tick();
        idle();
        #1;
        check("lw_cnt", {27'b0, hz.stallCnt}, 1);
        check("lw_released", {31'b0, hz.stallD}, 0);
        hz.memToRegE = 1; hz.writeRegE = 0; hz.rsD = 0;
        #1;
        check("lw_r0", {31'b0, hz.stallD}, 0);
        tick();
        check("lw_cnt_hold", {27'b0, hz.stallCnt}, 1);
        idle();

        // branch stall, then D-stage forward from M
        hz.branchD = 1; hz.pcSrcD = 1; hz.rsD = 3; hz.regWriteE = 1; hz.writeRegE = 3;
        #1;
        check("br_stall", {31'b0, hz.stallD}, 1);
        check("br_flushD_sup", {31'b0, hz.flushD}, 0);
        tick();
        check("br_cnt", {27'b0, hz.stallCnt}, 2);
        hz.regWriteE = 0; hz.writeRegE = 0; hz.writeRegM = 3; hz.regWriteM = 1;
        #1;
        check("br_go", {31'b0, hz.stallD}, 0);
        check("br_fwdAD", {31'b0, hz.forwardAD}, 1);
        check("br_fwdBD", {31'b0, hz.forwardBD}, 0);
        check("br_flushD", {31'b0, hz.flushD}, 1);
        hz.memToRegM = 1;
        #1;
        check("br_loadM", {31'b0, hz.stallD}, 1);
        idle();

        // divide: stall t..t+16, go at t+17
        clear_cnt();
        check("clr_cnt", {27'b0, hz.stallCnt}, 0);
        hz.mdStartE = 1; hz.mdDivE = 1; hz.mdUseD = 1;
        #1;
        check("div_t", {31'b0, hz.stallD}, 1);
        check("div_busy_t", {31'b0, hz.mdBusy}, 1);
        tick();
        hz.mdStartE = 0; hz.mdDivE = 0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            check($sformatf("div_t%0d", i), {31'b0, hz.stallD}, 1);
            tick();
        end
        #1;
        check("div_t17", {31'b0, hz.stallD}, 0);
        check("div_busy_t17", {31'b0, hz.mdBusy}, 0);
        check("div_cnt", {27'b0, hz.stallCnt}, 17);
        idle();

        // mult: stall t..t+3
        hz.mdStartE = 1; hz.mdUseD = 1;
        tick();
        hz.mdStartE = 0;
        tick(); tick();
        #1;
        check("mul_t3", {31'b0, hz.stallD}, 1);
        tick();
        check("mul_t4", {31'b0, hz.stallD}, 0);
        check("mul_cnt", {27'b0, hz.stallCnt}, 21);
        idle();

        // mult in flight, reset abandons it
        hz.mdStartE = 1;
        tick();
        hz.mdStartE = 0;
        #1;
        check("mul_busy", {31'b0, hz.mdBusy}, 1);
        rst_n = 0;
        #1;
        check("rst_busy", {31'b0, hz.mdBusy}, 0);
        check("rst_cnt2", {27'b0, hz.stallCnt}, 0);
        hz.pcSrcD = 1;
        #1;
        check("rst_flushD", {31'b0, hz.flushD}, 1);
        rst_n = 1;
        tick();
        check("post_rst_busy", {31'b0, hz.mdBusy}, 0);
        idle();

        // saturation and clear-over-stall
        hz.memToRegE = 1; hz.writeRegE = 9; hz.rsD = 9;
        for (int i = 0; i < 40; i++) tick();
        check("sat_cnt", {27'b0, hz.stallCnt}, 31);
        hz.clrStallCnt = 1;
        tick();
        check("clr_over_stall", {27'b0, hz.stallCnt}, 0);
        hz.clrStallCnt = 0;
        tick();
        check("count_resume", {27'b0, hz.stallCnt}, 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
